// File: rtl/arm_ctrl_pkg.sv
// Shared encodings for the pipelined ARM control path: opcodes, ALU commands,
// condition codes, immediate/flag-write selects and the inter-stage control bundles.
package arm_ctrl_pkg;

   localparam logic [1:0] OP_DP  = 2'b00;
   localparam logic [1:0] OP_MEM = 2'b01;
   localparam logic [1:0] OP_BR  = 2'b10;

   localparam logic [3:0] CMD_AND = 4'b0000;
   localparam logic [3:0] CMD_SUB = 4'b0010;
   localparam logic [3:0] CMD_ADD = 4'b0100;
   localparam logic [3:0] CMD_CMP = 4'b1010;
   localparam logic [3:0] CMD_ORR = 4'b1100;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;
   localparam logic [3:0] ALU_AND = 4'b0010;
   localparam logic [3:0] ALU_ORR = 4'b0011;

   localparam logic [3:0] COND_EQ = 4'h0;
   localparam logic [3:0] COND_NE = 4'h1;
   localparam logic [3:0] COND_CS = 4'h2;
   localparam logic [3:0] COND_CC = 4'h3;
   localparam logic [3:0] COND_MI = 4'h4;
   localparam logic [3:0] COND_PL = 4'h5;
   localparam logic [3:0] COND_VS = 4'h6;
   localparam logic [3:0] COND_VC = 4'h7;
   localparam logic [3:0] COND_HI = 4'h8;
   localparam logic [3:0] COND_LS = 4'h9;
   localparam logic [3:0] COND_GE = 4'hA;
   localparam logic [3:0] COND_LT = 4'hB;
   localparam logic [3:0] COND_GT = 4'hC;
   localparam logic [3:0] COND_LE = 4'hD;
   localparam logic [3:0] COND_AL = 4'hE;

   localparam logic [1:0] IMM_8  = 2'b00;
   localparam logic [1:0] IMM_12 = 2'b01;
   localparam logic [1:0] IMM_24 = 2'b10;

   localparam logic [1:0] FW_NONE = 2'b00;
   localparam logic [1:0] FW_NZ   = 2'b10;
   localparam logic [1:0] FW_ALL  = 2'b11;

   typedef struct packed {
      logic       pcsrc;
      logic       reg_write;
      logic       mem_to_reg;
      logic       mem_write;
      logic [3:0] alu_control;
      logic       branch;
      logic       alu_src;
      logic [1:0] flag_write;
      logic [3:0] cond;
   } ctrl_e_t;

   typedef struct packed {
      logic pcsrc;
      logic reg_write;
      logic mem_to_reg;
      logic mem_write;
   } ctrl_m_t;

   typedef struct packed {
      logic pcsrc;
      logic reg_write;
      logic mem_to_reg;
   } ctrl_w_t;

endpackage

// File: rtl/cond_unit.sv
// Execute-stage condition check: holds NZCV, evaluates the condition field
// against the pre-update flags and gates the architecturally visible writes.
module cond_unit
   import arm_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] cond_e,
   input  logic [1:0] flag_write_e,
   input  logic [3:0] alu_flags_e,
   input  logic       reg_write_e,
   input  logic       mem_write_e,
   input  logic       pcsrc_e,
   input  logic       branch_e,
   output logic       cond_ex_e,
   output logic       reg_write_g,
   output logic       mem_write_g,
   output logic       pcsrc_g,
   output logic       branch_taken_e
);

   logic [3:0] flags_q, flags_d;
   logic       n, z, c, v;

   assign {n, z, c, v} = flags_q;

   always_comb begin
      cond_ex_e = 1'b0;
      case (cond_e)
         COND_EQ: cond_ex_e = z;
         COND_NE: cond_ex_e = ~z;
         COND_CS: cond_ex_e = c;
         COND_CC: cond_ex_e = ~c;
         COND_MI: cond_ex_e = n;
         COND_PL: cond_ex_e = ~n;
         COND_VS: cond_ex_e = v;
         COND_VC: cond_ex_e = ~v;
         COND_HI: cond_ex_e = c & ~z;
         COND_LS: cond_ex_e = ~c | z;
         COND_GE: cond_ex_e = (n == v);
         COND_LT: cond_ex_e = (n != v);
         COND_GT: cond_ex_e = ~z & (n == v);
         COND_LE: cond_ex_e = z | (n != v);
         COND_AL: cond_ex_e = 1'b1;
         default: cond_ex_e = 1'b0;
      endcase
   end

   // Flags written here become visible to the next instruction in E, so a
   // compare followed directly by a conditional op needs no stall.
   always_comb begin
      flags_d = flags_q;
      if (flag_write_e[1] & cond_ex_e) flags_d[3:2] = alu_flags_e[3:2];
      if (flag_write_e[0] & cond_ex_e) flags_d[1:0] = alu_flags_e[1:0];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) flags_q <= 4'b0000;
      else        flags_q <= flags_d;
   end

   assign reg_write_g    = reg_write_e & cond_ex_e;
   assign mem_write_g    = mem_write_e & cond_ex_e;
   assign pcsrc_g        = pcsrc_e & cond_ex_e;
   assign branch_taken_e = branch_e & cond_ex_e;

endmodule

// File: rtl/control_pipeline.sv
// Pipelined ARM controller: decodes in D and carries control bits through the
// D->E, E->M and M->W registers alongside the datapath.
module control_pipeline
   import arm_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [19:0] InstrD,
   input  logic [3:0]  ALUFlagsE,
   input  logic        FlushE,
   output logic [1:0]  RegSrcD,
   output logic [1:0]  ImmSrcD,
   output logic        ALUSrcE,
   output logic [3:0]  ALUControlE,
   output logic        BranchTakenE,
   output logic        MemtoRegE,
   output logic        RegWriteM,
   output logic        MemWriteM,
   output logic        RegWriteW,
   output logic        MemtoRegW,
   output logic        PCSrcW,
   output logic        PCWrPendingF
);

   logic [3:0] cond_d, rd_d, cmd_d;
   logic [1:0] op_d;
   logic [5:0] funct_d;
   logic       unused_rn;
   ctrl_e_t    dec_d, de_d, de_q;
   ctrl_m_t    em_d, em_q;
   ctrl_w_t    mw_d, mw_q;
   logic       cond_ex_e, reg_write_g, mem_write_g, pcsrc_g;

   // InstrD carries bits [31:12] of the instruction word.
   assign cond_d    = InstrD[19:16];
   assign op_d      = InstrD[15:14];
   assign funct_d   = InstrD[13:8];
   assign rd_d      = InstrD[3:0];
   assign cmd_d     = funct_d[4:1];
   assign unused_rn = ^InstrD[7:4];

   always_comb begin
      dec_d   = '0;
      RegSrcD = 2'b00;
      ImmSrcD = IMM_8;
      dec_d.alu_control = ALU_ADD;
      dec_d.cond        = cond_d;
      case (op_d)
         OP_DP: begin
            dec_d.alu_src = funct_d[5];
            case (cmd_d)
               CMD_ADD: begin
                  dec_d.alu_control = ALU_ADD;
                  dec_d.reg_write   = 1'b1;
                  dec_d.flag_write  = funct_d[0] ? FW_ALL : FW_NONE;
               end
               CMD_SUB: begin
                  dec_d.alu_control = ALU_SUB;
                  dec_d.reg_write   = 1'b1;
                  dec_d.flag_write  = funct_d[0] ? FW_ALL : FW_NONE;
               end
               CMD_AND: begin
                  dec_d.alu_control = ALU_AND;
                  dec_d.reg_write   = 1'b1;
                  dec_d.flag_write  = funct_d[0] ? FW_NZ : FW_NONE;
               end
               CMD_ORR: begin
                  dec_d.alu_control = ALU_ORR;
                  dec_d.reg_write   = 1'b1;
                  dec_d.flag_write  = funct_d[0] ? FW_NZ : FW_NONE;
               end
               CMD_CMP: begin
                  dec_d.alu_control = ALU_SUB;
                  dec_d.flag_write  = FW_ALL;
               end
               default: ;
            endcase
         end
         OP_MEM: begin
            dec_d.alu_src     = 1'b1;
            ImmSrcD           = IMM_12;
            dec_d.alu_control = funct_d[3] ? ALU_ADD : ALU_SUB;
            if (funct_d[0]) begin
               dec_d.reg_write  = 1'b1;
               dec_d.mem_to_reg = 1'b1;
            end else begin
               dec_d.mem_write = 1'b1;
               RegSrcD[1]      = 1'b1;
            end
         end
         OP_BR: begin
            dec_d.branch  = 1'b1;
            dec_d.alu_src = 1'b1;
            ImmSrcD       = IMM_24;
            RegSrcD[0]    = 1'b1;
         end
         default: ;
      endcase
      dec_d.pcsrc = ((rd_d == 4'hF) & dec_d.reg_write) | dec_d.branch;
   end

   always_comb begin
      de_d = FlushE ? '0 : dec_d;
      em_d = '{pcsrc: pcsrc_g, reg_write: reg_write_g,
               mem_to_reg: de_q.mem_to_reg, mem_write: mem_write_g};
      mw_d = '{pcsrc: em_q.pcsrc, reg_write: em_q.reg_write,
               mem_to_reg: em_q.mem_to_reg};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         de_q <= '0;
         em_q <= '0;
         mw_q <= '0;
      end else begin
         de_q <= de_d;
         em_q <= em_d;
         mw_q <= mw_d;
      end
   end

   cond_unit u_cond_unit (
      .clk            (clk),
      .reset          (reset),
      .cond_e         (de_q.cond),
      .flag_write_e   (de_q.flag_write),
      .alu_flags_e    (ALUFlagsE),
      .reg_write_e    (de_q.reg_write),
      .mem_write_e    (de_q.mem_write),
      .pcsrc_e        (de_q.pcsrc),
      .branch_e       (de_q.branch),
      .cond_ex_e      (cond_ex_e),
      .reg_write_g    (reg_write_g),
      .mem_write_g    (mem_write_g),
      .pcsrc_g        (pcsrc_g),
      .branch_taken_e (BranchTakenE)
   );

   assign ALUSrcE      = de_q.alu_src;
   assign ALUControlE  = de_q.alu_control;
   assign MemtoRegE    = de_q.mem_to_reg;
   assign RegWriteM    = em_q.reg_write;
   assign MemWriteM    = em_q.mem_write;
   assign RegWriteW    = mw_q.reg_write;
   assign MemtoRegW    = mw_q.mem_to_reg;
   assign PCSrcW       = mw_q.pcsrc;
   assign PCWrPendingF = dec_d.pcsrc | de_q.pcsrc | em_q.pcsrc;

endmodule

// File: tb/tb_control_pipeline.sv
// Directed bench for control_pipeline: hand-encoded instructions stepped through
// the pipeline with immediate assertions at each observation point.
module tb_control_pipeline;

   logic        clk;
   logic        reset;
   logic [19:0] InstrD;
   logic [3:0]  ALUFlagsE;
   logic        FlushE;
   logic [1:0]  RegSrcD, ImmSrcD;
   logic        ALUSrcE;
   logic [3:0]  ALUControlE;
   logic        BranchTakenE, MemtoRegE, RegWriteM, MemWriteM;
   logic        RegWriteW, MemtoRegW, PCSrcW, PCWrPendingF;

   int n_total = 0;
   int n_pass  = 0;

   // Upper 20 bits of the hand-assembled instruction words.
   localparam logic [19:0] I_NOP   = 20'hEC000;
   localparam logic [19:0] I_ADDS  = 20'hE2921;  // ADDS R1,R2,#5
   localparam logic [19:0] I_CMP   = 20'hE3510;  // CMP R1,#0
   localparam logic [19:0] I_BEQ   = 20'h0A000;  // BEQ
   localparam logic [19:0] I_STRNE = 20'h15821;  // STRNE R1,[R2,#4]
   localparam logic [19:0] I_LDR   = 20'hE5921;  // LDR R1,[R2]
   localparam logic [19:0] I_MOVPC = 20'hE28FF;  // ADD R15,R15,#4
   localparam logic [19:0] I_BNV   = 20'hFA000;  // branch, cond 1111

   control_pipeline dut (
      .clk          (clk),
      .reset        (reset),
      .InstrD       (InstrD),
      .ALUFlagsE    (ALUFlagsE),
      .FlushE       (FlushE),
      .RegSrcD      (RegSrcD),
      .ImmSrcD      (ImmSrcD),
      .ALUSrcE      (ALUSrcE),
      .ALUControlE  (ALUControlE),
      .BranchTakenE (BranchTakenE),
      .MemtoRegE    (MemtoRegE),
      .RegWriteM    (RegWriteM),
      .MemWriteM    (MemWriteM),
      .RegWriteW    (RegWriteW),
      .MemtoRegW    (MemtoRegW),
      .PCSrcW       (PCSrcW),
      .PCWrPendingF (PCWrPendingF)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic chk_regs_zero(input string tag);
      chk(tag, {4'h0, ALUSrcE, ALUControlE, BranchTakenE, MemtoRegE, RegWriteM,
                MemWriteM, RegWriteW, MemtoRegW, PCSrcW}, 16'h0000);
   endtask

   initial begin
      reset = 1'b0; InstrD = I_NOP; ALUFlagsE = 4'h0; FlushE = 1'b0;

      // Reset held with random instructions in D
      for (int i = 0; i < 3; i++) begin
         InstrD = 20'($urandom_range(0, 20'hFFFFF));
         tick();
         chk_regs_zero("rst_regs");
      end
      InstrD = I_BEQ; #1;
      chk("rst_dec_regsrc", 16'(RegSrcD), 16'h1);
      chk("rst_dec_immsrc", 16'(ImmSrcD), 16'h2);
      InstrD = I_NOP; #1;
      reset = 1'b1;
      repeat (3) tick();
      chk_regs_zero("post_rst_regs");

      // ADDS sets Z; following BEQ sees it
      InstrD = I_ADDS; #1;
      chk("adds_pcwr", 16'(PCWrPendingF), 16'h0);
      tick();
      InstrD = I_BEQ; ALUFlagsE = 4'b0100; #1;
      chk("adds_aluctl", 16'(ALUControlE), 16'h0);
      chk("adds_alusrc", 16'(ALUSrcE), 16'h1);
      chk("adds_btaken", 16'(BranchTakenE), 16'h0);
      tick();
      InstrD = I_NOP; ALUFlagsE = 4'h0; #1;
      chk("adds_beq_taken", 16'(BranchTakenE), 16'h1);
      chk("adds_regwr_m", 16'(RegWriteM), 16'h1);
      tick();
      chk("adds_regwr_w", 16'(RegWriteW), 16'h1);

      // CMP clearing Z, then BEQ not taken
      InstrD = I_CMP; tick();
      InstrD = I_BEQ; ALUFlagsE = 4'b0000; #1;
      chk("cmp_aluctl", 16'(ALUControlE), 16'h1);
      tick();
      InstrD = I_NOP; #1;
      chk("cmp0_beq", 16'(BranchTakenE), 16'h0);
      chk("cmp_no_regwr", 16'(RegWriteM), 16'h0);

      // CMP setting Z, then BEQ taken
      InstrD = I_CMP; tick();
      InstrD = I_BEQ; ALUFlagsE = 4'b0100; tick();
      InstrD = I_NOP; ALUFlagsE = 4'h0; #1;
      chk("cmp1_beq", 16'(BranchTakenE), 16'h1);

      // STRNE with Z=1 is suppressed
      InstrD = I_STRNE; #1;
      chk("str_regsrc", 16'(RegSrcD), 16'h2);
      chk("str_immsrc", 16'(ImmSrcD), 16'h1);
      tick();
      InstrD = I_NOP; tick();
      chk("strne_z1", 16'(MemWriteM), 16'h0);

      // STRNE with Z=0 writes for exactly one cycle
      InstrD = I_CMP; tick();
      InstrD = I_STRNE; ALUFlagsE = 4'b0000; tick();
      InstrD = I_NOP; tick();
      chk("strne_z0", 16'(MemWriteM), 16'h1);
      tick();
      chk("strne_one_cycle", 16'(MemWriteM), 16'h0);

      // LDR flushed on its way into E
      InstrD = I_LDR; FlushE = 1'b1; tick();
      FlushE = 1'b0; InstrD = I_NOP; #1;
      chk("flush_m2r_e", 16'(MemtoRegE), 16'h0);
      tick();
      chk("flush_regwr_m", 16'(RegWriteM), 16'h0);
      tick();
      chk("flush_regwr_w", 16'({RegWriteW, MemtoRegW}), 16'h0);

      // LDR without flush reaches W
      InstrD = I_LDR; tick();
      InstrD = I_NOP; #1;
      chk("ldr_m2r_e", 16'(MemtoRegE), 16'h1);
      tick(); tick();
      chk("ldr_w", 16'({RegWriteW, MemtoRegW}), 16'h3);

      // Flush does not cancel the flag update of the op already in E
      InstrD = I_CMP; tick();
      InstrD = I_BEQ; FlushE = 1'b1; ALUFlagsE = 4'b0100; tick();
      FlushE = 1'b0; ALUFlagsE = 4'h0; InstrD = I_BEQ; #1;
      chk("flushed_beq", 16'(BranchTakenE), 16'h0);
      tick();
      InstrD = I_NOP; #1;
      chk("flag_under_flush", 16'(BranchTakenE), 16'h1);

      // Condition 1111 never executes
      InstrD = I_BNV; tick();
      InstrD = I_NOP; #1;
      chk("cond_nv", 16'(BranchTakenE), 16'h0);
      tick();

      // Write to R15: pending through D/E/M, then PCSrcW for one cycle
      InstrD = I_MOVPC; #1;
      chk("pc_pend_d", 16'(PCWrPendingF), 16'h1);
      tick();
      InstrD = I_NOP; #1;
      chk("pc_pend_e", 16'(PCWrPendingF), 16'h1);
      tick();
      chk("pc_pend_m", 16'({PCWrPendingF, PCSrcW}), 16'h2);
      tick();
      chk("pc_srcw", 16'({PCWrPendingF, PCSrcW}), 16'h1);
      tick();
      chk("pc_srcw_gone", 16'(PCSrcW), 16'h0);

      // Asynchronous reset mid-stream; flags also cleared (Z was 1)
      InstrD = I_LDR; tick();
      InstrD = I_NOP; #1;
      reset = 1'b0; #1;
      chk("async_rst_m2r", 16'(MemtoRegE), 16'h0);
      tick();
      reset = 1'b1;
      tick(); tick();
      chk_regs_zero("rst_mid_regs");
      InstrD = I_BEQ; tick();
      InstrD = I_NOP; #1;
      chk("rst_flags_clear", 16'(BranchTakenE), 16'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
